// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Purpose  : Opcode encodings, the opcode type and the legality check for the
//            pipelined ALU execution stage.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND     = 4'b0000;
  localparam alu_op_t ALU_OR      = 4'b0001;
  localparam alu_op_t ALU_ADD     = 4'b0010;
  localparam alu_op_t ALU_SUB     = 4'b0100;
  localparam alu_op_t ALU_SUB_ALT = 4'b0110;
  localparam alu_op_t ALU_SLT     = 4'b0111;
  localparam alu_op_t ALU_SRL     = 4'b1000;
  localparam alu_op_t ALU_SLL     = 4'b1001;
  localparam alu_op_t ALU_SRA     = 4'b1010;
  localparam alu_op_t ALU_XOR     = 4'b1101;

  // True for every code the decoder can legitimately produce.
  function automatic logic is_legal_op(input alu_op_t op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SUB_ALT,
      ALU_SLT, ALU_SRL, ALU_SLL, ALU_SRA, ALU_XOR: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Purely combinational ALU datapath: result, zero, signed overflow
//            and illegal-opcode flags. Overflow logic is only built when the
//            ALU_PIPE_OVF_EN macro is defined; otherwise ovf is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]        sum;
  logic [WIDTH-1:0]        diff;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] sra_res;

  // Carry-out is discarded: both are plain modulo-2^WIDTH results.
  assign sum     = a + b;
  assign diff    = a - b;
  assign shamt   = b[SHW-1:0];
  assign sra_res = $signed(a) >>> shamt;

  assign illegal = !is_legal_op(op);
  assign zero    = (result == '0);

  // Operation select; undefined codes fall through to a zero result.
  always_comb begin
    result = '0;
    case (op)
      ALU_AND:              result = a & b;
      ALU_OR:               result = a | b;
      ALU_XOR:              result = a ^ b;
      ALU_ADD:              result = sum;
      ALU_SUB, ALU_SUB_ALT: result = diff;
      ALU_SLT:              result[0] = ($signed(a) < $signed(b));
      ALU_SRL:              result = a >> shamt;
      ALU_SLL:              result = a << shamt;
      ALU_SRA:              result = sra_res;
      default:              result = '0;
    endcase
  end

`ifdef ALU_PIPE_OVF_EN
  logic add_ovf;
  logic sub_ovf;

  // ADD: same-sign operands producing a result of the other sign.
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  // SUB: different-sign operands where the result sign departs from a.
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Overflow is only meaningful for the arithmetic opcodes.
  always_comb begin
    ovf = 1'b0;
    if (op == ALU_ADD) begin
      ovf = add_ovf;
    end else if ((op == ALU_SUB) || (op == ALU_SUB_ALT)) begin
      ovf = sub_ovf;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage pipelined ALU execution stage with valid/ready
//            handshake. S1 registers op/operands, S2 registers result/flags
//            computed by alu_core. Backpressure propagates stage by stage.
//            Optional macro ALU_PIPE_OVF_EN enables signed-overflow logic.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  logic             s1_valid;
  alu_op_t          s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s1_load;
  logic             s2_load;
  logic             s2_free;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ovf;
  logic             core_illegal;

  // S2 can take a new result when empty or when its current one leaves now.
  assign s2_free  = !out_valid || out_ready;
  assign s2_load  = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign s1_load  = in_valid && in_ready;

  // Input register: loads on accept, empties when drained with nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= ALU_AND;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_op    <= alu_op;
      s1_a     <= op1;
      s1_b     <= op2;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op      (s1_op),
    .a       (s1_a),
    .b       (s1_b),
    .result  (core_result),
    .zero    (core_zero),
    .ovf     (core_ovf),
    .illegal (core_illegal)
  );

  // Output register: result and flags only change when S1 drains into S2,
  // so they stay stable while a stalled result waits for out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      result    <= core_result;
      zero      <= core_zero;
      ovf       <= core_ovf;
      illegal   <= core_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Scoreboard bench for alu_pipe: directed vectors push expected
//            responses; an independent monitor pops and compares on every
//            output transfer and checks that stalled outputs hold.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

`ifdef ALU_PIPE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t sb[$];

  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Present one transaction until accepted; push its expected response.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic z, input logic o, input logic il);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    alu_op   = op;
    op1      = a;
    op2      = b;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: op %b not accepted in 20 cycles", op);
    end else begin
      sb.push_back('{res: r, z: z, o: o & OVF_ON, il: il});
    end
    in_valid = 1'b0;
  endtask

  // Monitor: compare each transferred result against the scoreboard and
  // confirm a stalled result does not change.
  logic        held;
  logic [31:0] h_res;
  logic [2:0]  h_flags;
  initial held = 1'b0;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held) begin
        vectors++;
        if (result !== h_res || {zero, ovf, illegal} !== h_flags) begin
          miscompares++;
          $display("FAIL hold: got 0x%08h/%b, expected 0x%08h/%b",
                   result, {zero, ovf, illegal}, h_res, h_flags);
        end
      end
      if (out_ready) begin
        held = 1'b0;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got 0x%08h, expected no output", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (result !== e.res || zero !== e.z || ovf !== e.o || illegal !== e.il) begin
            miscompares++;
            $display("FAIL result: got 0x%08h z%b o%b il%b, expected 0x%08h z%b o%b il%b",
                     result, zero, ovf, illegal, e.res, e.z, e.o, e.il);
          end
        end
      end else begin
        held    = 1'b1;
        h_res   = result;
        h_flags = {zero, ovf, illegal};
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_op    = 4'b0000;
    op1       = '0;
    op2       = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_result", result, 32'd0);
    check("idle_flags", {29'd0, zero, ovf, illegal}, 32'd0);

    // ADD overflow with latency check: accepted at edge N, valid after N+1.
    send(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    check("latency_not_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("latency_valid", {31'd0, out_valid}, 32'd1);

    send(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    send(4'b0100, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    send(4'b0100, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send(4'b1010, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    send(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    send(4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
    send(4'b1000, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
    send(4'b1001, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    send(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
    send(4'b1101, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0);
    send(4'b0011, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 4 back-to-back ADDs, out_ready low 3 cycles after the
    // first result appears.
    fork
      begin
        send(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        send(4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0);
        send(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        send(4'b0010, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1, 1'b0);
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_first_result_seen", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_drained", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset with both stages full: everything in flight is discarded.
    out_ready = 1'b0;
    send(4'b0010, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0, 1'b0);
    send(4'b0010, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("full_before_rst", {30'd0, out_valid, in_ready}, 32'd2);
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, zero, ovf, illegal}, 32'd0);
    check("rst_s1_valid", {31'd0, dut.s1_valid}, 32'd0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_output_after_rst", {31'd0, out_valid}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
